// File: rtl/memory_instruction_pkg.sv
// Shared definitions for the RV32I load/store unit: funct3 codes, FSM states and address map.
package memory_instruction_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [31:0] RAM_BASE        = 32'h0000_0000;
  localparam logic [31:0] IO_ADDR_DEFAULT = 32'h0000_2000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_CLEAR = 2'd2
  } mem_state_e;

endpackage

// File: rtl/memory_instruction_data_ram.sv
// Word-organised synchronous data RAM with per-byte write enables and a registered read port.
module memory_instruction_data_ram #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        be,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata_p1
);

  localparam int WORDS = 1 << ADDR_W;

  logic [31:0] mem [WORDS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    rdata_p1 <= mem[addr];
  end

endmodule

// File: rtl/memory_instruction.sv
// RV32I load/store execution unit: byte RAM, one 8-bit memory-mapped output, one-cycle load stall.
// Optional MEMORY_INIT_CLEAR_EN: zero the whole RAM after reset while holding clk_stall.
module memory_instruction
  import memory_instruction_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 4096,
  parameter logic [31:0] IO_ADDR   = IO_ADDR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  subfunction_3,
  input  logic [31:0] input_register1_value,
  input  logic [31:0] input_register2_value,
  input  logic [31:0] immediate,
  input  logic        opcode_is_store,
  input  logic        opcode_is_load,
  output logic        clk_stall,
  output logic        load_error,
  output logic        store_error,
  output logic [31:0] result_to_write_rd,
  output logic [7:0]  memory_mapped_io
);

  localparam int BYTE_AW = $clog2(MEM_BYTES);
  localparam int WORD_AW = BYTE_AW - 2;

`ifdef MEMORY_INIT_CLEAR_EN
  localparam mem_state_e RST_STATE = ST_CLEAR;
`else
  localparam mem_state_e RST_STATE = ST_IDLE;
`endif

  function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic zero_ext);
    logic signed [7:0]  sb;
    logic signed [31:0] sx;
    sb = b;
    sx = 32'(sb);
    return zero_ext ? {24'h0, b} : sx;
  endfunction

  function automatic logic [31:0] ext_half(input logic [15:0] h, input logic zero_ext);
    logic signed [15:0] sh;
    logic signed [31:0] sx;
    sh = h;
    sx = 32'(sh);
    return zero_ext ? {16'h0, h} : sx;
  endfunction

  logic [31:0]        addr;
  logic [31:0]        ram_off;
  logic               in_ram, is_io, misaligned;
  logic               is_load, is_store;
  logic               load_f3_ok, store_f3_ok, load_ok, store_ok;
  logic [3:0]         store_be;
  logic [31:0]        store_data;
  mem_state_e         state, state_nxt;
  logic [WORD_AW-1:0] ram_addr;
  logic [3:0]         ram_be;
  logic [31:0]        ram_wdata;
  logic [31:0]        rd_data_p1;

  assign addr     = input_register1_value + immediate;
  assign ram_off  = addr - RAM_BASE;
  assign in_ram   = (ram_off[31:BYTE_AW] == '0);
  assign is_io    = (addr == IO_ADDR);
  assign is_store = opcode_is_store;
  assign is_load  = opcode_is_load && !opcode_is_store;

  // Legality: funct3 set, natural alignment, and target either RAM or byte-wide IO
  always_comb begin
    load_f3_ok  = (subfunction_3 == F3_LB) || (subfunction_3 == F3_LH) ||
                  (subfunction_3 == F3_LW) || (subfunction_3 == F3_LBU) ||
                  (subfunction_3 == F3_LHU);
    store_f3_ok = (subfunction_3 == F3_SB) || (subfunction_3 == F3_SH) ||
                  (subfunction_3 == F3_SW);
    misaligned  = ((subfunction_3[1:0] == 2'b01) && addr[0]) ||
                  ((subfunction_3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    load_ok     = load_f3_ok && !misaligned &&
                  (in_ram || (is_io && (subfunction_3[1:0] == 2'b00)));
    store_ok    = store_f3_ok && !misaligned &&
                  (in_ram || (is_io && (subfunction_3 == F3_SB)));
  end

  assign load_error  = is_load && !load_ok;
  assign store_error = is_store && !store_ok;

  always_comb begin
    store_be   = 4'hF;
    store_data = input_register2_value;
    case (subfunction_3[1:0])
      2'b00: begin
        store_be   = 4'b0001 << addr[1:0];
        store_data = {4{input_register2_value[7:0]}};
      end
      2'b01: begin
        store_be   = addr[1] ? 4'b1100 : 4'b0011;
        store_data = {2{input_register2_value[15:0]}};
      end
      default: ;
    endcase
  end

`ifdef MEMORY_INIT_CLEAR_EN
  logic [WORD_AW-1:0] clr_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  clr_idx <= '0;
    else if (state == ST_CLEAR) clr_idx <= clr_idx + WORD_AW'(1);
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RST_STATE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    clk_stall = 1'b0;
    ram_addr  = addr[BYTE_AW-1:2];
    ram_be    = 4'h0;
    ram_wdata = store_data;
    case (state)
      ST_IDLE: begin
        if (is_load) begin
          clk_stall = 1'b1;
          state_nxt = ST_WAIT;
        end else if (is_store && store_ok && in_ram) begin
          ram_be = store_be;
        end
      end
      ST_WAIT: state_nxt = ST_IDLE;
`ifdef MEMORY_INIT_CLEAR_EN
      ST_CLEAR: begin
        clk_stall = 1'b1;
        ram_addr  = clr_idx;
        ram_be    = 4'hF;
        ram_wdata = '0;
        if (clr_idx == '1) state_nxt = ST_IDLE;
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
    // The core must never be held while reset is asserted
    if (reset) clk_stall = 1'b0;
  end

  memory_instruction_data_ram #(
    .ADDR_W(WORD_AW)
  ) data_ram (
    .clk      (clk),
    .addr     (ram_addr),
    .be       (ram_be),
    .wdata    (ram_wdata),
    .rdata_p1 (rd_data_p1)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) memory_mapped_io <= 8'h00;
    else if ((state == ST_IDLE) && is_store && store_ok && is_io)
      memory_mapped_io <= input_register2_value[7:0];
  end

  // ---- stage p1: registered RAM word is lane-selected and extended in WAIT ----
  always_comb begin
    result_to_write_rd = '0;
    if ((state == ST_WAIT) && is_load && load_ok) begin
      if (is_io) begin
        result_to_write_rd = ext_byte(memory_mapped_io, subfunction_3[2]);
      end else begin
        case (subfunction_3[1:0])
          2'b00:   result_to_write_rd = ext_byte(rd_data_p1[{addr[1:0], 3'b000} +: 8],
                                                 subfunction_3[2]);
          2'b01:   result_to_write_rd = ext_half(rd_data_p1[{addr[1], 4'b0000} +: 16],
                                                 subfunction_3[2]);
          default: result_to_write_rd = rd_data_p1;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_memory_instruction.sv
// Randomised self-checking bench for memory_instruction against a byte-array reference model.
module tb_memory_instruction;
  import memory_instruction_pkg::*;

  localparam int          MEM_BYTES = 4096;
  localparam logic [31:0] IO_ADDR   = 32'h0000_2000;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  subfunction_3;
  logic [31:0] input_register1_value;
  logic [31:0] input_register2_value;
  logic [31:0] immediate;
  logic        opcode_is_store;
  logic        opcode_is_load;
  logic        clk_stall;
  logic        load_error;
  logic        store_error;
  logic [31:0] result_to_write_rd;
  logic [7:0]  memory_mapped_io;

  memory_instruction #(
    .MEM_BYTES(MEM_BYTES),
    .IO_ADDR  (IO_ADDR)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .subfunction_3         (subfunction_3),
    .input_register1_value (input_register1_value),
    .input_register2_value (input_register2_value),
    .immediate             (immediate),
    .opcode_is_store       (opcode_is_store),
    .opcode_is_load        (opcode_is_load),
    .clk_stall             (clk_stall),
    .load_error            (load_error),
    .store_error           (store_error),
    .result_to_write_rd    (result_to_write_rd),
    .memory_mapped_io      (memory_mapped_io)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  ref_mem [MEM_BYTES];
  logic [7:0]  ref_io;
  logic [31:0] exp_lbu [4] = '{32'h10, 32'hBA, 32'hDC, 32'hFE};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int acc_size(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic bit ref_legal(input bit is_ld, input logic [2:0] f3, input logic [31:0] a);
    int sz = acc_size(f3);
    if (sz == 0 || (!is_ld && f3 > 3'd2)) return 1'b0;
    if ((a % 32'(sz)) != 32'd0) return 1'b0;
    if (a == IO_ADDR) return (sz == 1);
    return (a < 32'(MEM_BYTES));
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    int          sz = acc_size(f3);
    logic [63:0] v  = 64'h0;
    if (a == IO_ADDR) v = {56'h0, ref_io};
    else for (int i = 0; i < sz; i++) v = v | (64'(ref_mem[int'(a) + i]) << (8 * i));
    if (f3 < 3'd4 && sz < 4 && v[8*sz-1]) v = v | (~64'h0 << (8 * sz));
    return v[31:0];
  endfunction

  function automatic void ref_store(input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] d);
    if (a == IO_ADDR) ref_io = d[7:0];
    else for (int i = 0; i < acc_size(f3); i++) ref_mem[int'(a) + i] = d[8*i +: 8];
  endfunction

  function automatic void ref_reset();
    ref_io = 8'h00;
`ifdef MEMORY_INIT_CLEAR_EN
    for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'h00;
`endif
  endfunction

  task automatic set_nop();
    opcode_is_store       = 1'b0;
    opcode_is_load        = 1'b0;
    subfunction_3         = 3'($urandom);
    input_register1_value = $urandom;
    input_register2_value = $urandom;
    immediate             = $urandom;
  endtask

  task automatic wait_ready();
    int cyc = 0;
    while (clk_stall !== 1'b0 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    check("ready.stall", 32'(clk_stall), 32'h0);
  endtask

  task automatic do_nop();
    @(negedge clk);
    set_nop();
    #1;
    check("nop.rd", result_to_write_rd, 32'h0);
    check("nop.err", {30'h0, load_error, store_error}, 32'h0);
    check("nop.stall", 32'(clk_stall), 32'h0);
  endtask

  task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] base,
                          input logic [31:0] imm, input logic [31:0] data, input bit both);
    logic [31:0] a;
    bit          ok;
    @(negedge clk);
    subfunction_3         = f3;
    input_register1_value = base;
    immediate             = imm;
    input_register2_value = data;
    opcode_is_store       = 1'b1;
    opcode_is_load        = both;
    a  = base + imm;
    ok = ref_legal(1'b0, f3, a);
    #1;
    check({tag, ".serr"}, 32'(store_error), 32'(!ok));
    check({tag, ".lerr"}, 32'(load_error), 32'h0);
    check({tag, ".stall"}, 32'(clk_stall), 32'h0);
    check({tag, ".rd"}, result_to_write_rd, 32'h0);
    @(posedge clk);
    if (ok) ref_store(f3, a, data);
    #1;
    set_nop();
    check({tag, ".io"}, 32'(memory_mapped_io), 32'(ref_io));
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] base,
                         input logic [31:0] imm, output logic [31:0] got);
    logic [31:0] a, exp;
    bit          ok;
    @(negedge clk);
    subfunction_3         = f3;
    input_register1_value = base;
    immediate             = imm;
    input_register2_value = $urandom;
    opcode_is_store       = 1'b0;
    opcode_is_load        = 1'b1;
    a   = base + imm;
    ok  = ref_legal(1'b1, f3, a);
    exp = ok ? ref_load(f3, a) : 32'h0;
    #1;
    check({tag, ".lerr"}, 32'(load_error), 32'(!ok));
    check({tag, ".serr"}, 32'(store_error), 32'h0);
    check({tag, ".stall1"}, 32'(clk_stall), 32'h1);
    @(negedge clk);
    check({tag, ".stall0"}, 32'(clk_stall), 32'h0);
    check({tag, ".rd"}, result_to_write_rd, exp);
    got = result_to_write_rd;
    @(posedge clk);
    #1;
    set_nop();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] got, target, base;
    logic [2:0]  f3;
    int          op;

    reset = 1'b1;
    set_nop();
    ref_reset();
    repeat (3) @(negedge clk);
    check("rst.stall", 32'(clk_stall), 32'h0);
    check("rst.io", 32'(memory_mapped_io), 32'h0);
    check("rst.rd", result_to_write_rd, 32'h0);
    reset = 1'b0;
    wait_ready();

    for (int w = 0; w < 128; w++) do_store("init", F3_SW, 32'(w * 4), 32'h0, $urandom, 1'b0);

    do_store("d1.sw", F3_SW, 32'hEC, 32'h10, 32'hFEDCBA98, 1'b0);
    do_store("d1.sh", F3_SH, 32'hDE, 32'h20, 32'h00007654, 1'b0);
    do_store("d1.sb", F3_SB, 32'hFF, 32'h00, 32'h00000032, 1'b0);
    do_load("d1.lw", F3_LW, 32'hFB, 32'h1, got);
    check("d1.lw_const", got, 32'h3254BA98);
    check("d1.io_const", 32'(memory_mapped_io), 32'h0);

    do_store("d2.sw", F3_SW, 32'hFC, 32'h0, 32'hFEDCBA98, 1'b0);
    do_store("d2.sh", F3_SH, 32'hFC, 32'h0, 32'h00007654, 1'b0);
    do_store("d2.sb", F3_SB, 32'hFF, 32'h0, 32'h00000032, 1'b0);
    do_load("d2.lw", F3_LW, 32'hFC, 32'h0, got);

    do_store("d3.sw", F3_SW, 32'hFC, 32'h0, 32'hFEDCBA10, 1'b0);
    for (int k = 0; k < 4; k++) begin
      do_load("d3.lbu", F3_LBU, 32'hFC, 32'(k), got);
      check("d3.lbu_const", got, exp_lbu[k]);
    end
    do_load("d3.lhu0", F3_LHU, 32'hFC, 32'h0, got);
    check("d3.lhu0_const", got, 32'h0000BA10);
    do_load("d3.lhu2", F3_LHU, 32'hFC, 32'h2, got);
    check("d3.lhu2_const", got, 32'h0000FEDC);
    do_load("d3.lb2", F3_LB, 32'hFC, 32'h2, got);
    check("d3.lb2_const", got, 32'hFFFFFFDC);

    do_store("d4.io", F3_SB, 32'h1000, 32'h1000, 32'h000000D1, 1'b0);
    check("d4.io_const", 32'(memory_mapped_io), 32'hD1);
    do_load("d4.lbu_io", F3_LBU, 32'h2000, 32'h0, got);
    do_load("d4.lb_io", F3_LB, 32'h1FFF, 32'h1, got);

    do_load("e.lw_mis", F3_LW, 32'hFD, 32'h0, got);
    do_store("e.sh_mis", F3_SH, 32'hFF, 32'h0, 32'h1111, 1'b0);
    do_store("e.sw_oob", F3_SW, 32'h3000, 32'h0, 32'h22222222, 1'b0);
    do_store("e.sw_io", F3_SW, 32'h2000, 32'h0, 32'h33333333, 1'b0);
    do_load("e.lw_io", F3_LW, 32'h2000, 32'h0, got);
    do_load("e.f3_011", 3'b011, 32'hFC, 32'h0, got);
    do_store("e.f3_011", 3'b011, 32'hFC, 32'h0, 32'h44444444, 1'b0);
    do_load("e.after", F3_LW, 32'hFC, 32'h0, got);
    do_nop();

    // Reset in the stall cycle of a load
    @(negedge clk);
    subfunction_3         = F3_LW;
    input_register1_value = 32'hFC;
    immediate             = 32'h0;
    opcode_is_load        = 1'b1;
    #1;
    check("rmid.stall1", 32'(clk_stall), 32'h1);
    reset = 1'b1;
    #1;
    check("rmid.stall0", 32'(clk_stall), 32'h0);
    check("rmid.rd", result_to_write_rd, 32'h0);
    @(posedge clk);
    #1;
    check("rmid.stall_edge", 32'(clk_stall), 32'h0);
    check("rmid.io", 32'(memory_mapped_io), 32'h0);
    set_nop();
    @(negedge clk);
    reset = 1'b0;
    ref_reset();
    wait_ready();
    do_load("rmid.ram", F3_LW, 32'hFC, 32'h0, got);

    for (int n = 0; n < 400; n++) begin
      op = $urandom_range(0, 99);
      if (op < 75) target = 32'($urandom_range(0, 511));
      else if (op < 85) target = IO_ADDR + ((op % 3 == 0) ? 32'($urandom_range(0, 3)) : 32'h0);
      else begin
        case ($urandom_range(0, 3))
          0:       target = 32'h0000_3000;
          1:       target = 32'h0000_1000;
          2:       target = 32'hFFFF_FFFC;
          default: target = 32'h0000_2002;
        endcase
      end
      f3   = 3'($urandom_range(0, 7));
      base = $urandom;
      op   = $urandom_range(0, 9);
      if (op < 4)      do_store("rnd.st", f3, base, target - base, $urandom, 1'b0);
      else if (op < 8) do_load("rnd.ld", f3, base, target - base, got);
      else if (op == 8) do_nop();
      else             do_store("rnd.both", f3, base, target - base, $urandom, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
